seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
// - Time-multiplexes NUM_DIGITS hex nibbles onto one shared 7-segment decoder input.
// - Drives one-hot digit enables, with a guard gap between digits to prevent ghosting.
// - Sits directly upstream of the binary-to-7-segment decoder:
//   - bin_out feeds the decoder's 4-bit input.
//   - digit_sel drives the digit common lines.
// PARAMETERS
// - NUM_DIGITS   4      number of digits scanned; legal range 2..8
// - DWELL_CYCLES 50000  clk cycles each digit is driven; must be >= 2
// - GUARD_CYCLES 16     clk cycles with all digits off between digits; must be >= 1
// PORTS
// - clk         in   1              system clock; all logic on rising edge
// - rst         in   1              synchronous, active-high reset
// - digits_in   in   4*NUM_DIGITS   hex digits; digit 0 = bits [3:0] = rightmost
// - load        in   1              1-cycle strobe: capture digits_in into shadow reg
// - blank       in   1              level: force all digits off while high
// - bin_out     out  4              nibble of the currently driven digit (to decoder)
// - digit_sel   out  NUM_DIGITS     one-hot, active-high digit enable; all-0 = off
// - frame_done  out  1              1-cycle pulse when the last digit's dwell ends
// BEHAVIOUR
// - Reset (synchronous, active-high)
//   - shadow = 0, idx = 0, counter = 0, state = GUARD.
//   - Outputs: bin_out = 0, digit_sel = 0, frame_done = 0.
//   - Reset mid-scan aborts the current digit on the next edge; there is no partial-dwell carry.
// - Shadow register
//   - load = 1 copies digits_in on that edge.
//   - The new value is visible on bin_out from the next DRIVE cycle.
//   - The digit being driven changes value mid-dwell if load occurs during its DRIVE; this is allowed.
// - FSM has two states; counter is sized ceil(log2(max(DWELL_CYCLES, GUARD_CYCLES))) bits.
//   - GUARD
//     - digit_sel = 0; counter increments.
//     - When counter == GUARD_CYCLES-1: counter <= 0, state <= DRIVE.
//   - DRIVE
//     - digit_sel = 1 << idx; bin_out = shadow[4*idx +: 4].
//     - When counter == DWELL_CYCLES-1: counter <= 0, state <= GUARD, idx advances.
//     - idx wraps from NUM_DIGITS-1 to 0.
//     - frame_done = 1 on the edge leaving DRIVE with idx == NUM_DIGITS-1.
// - Outputs are registered: one cycle of latency from state/idx change to the outputs.
// - Period: one digit = GUARD_CYCLES + DWELL_CYCLES cycles; frame = NUM_DIGITS x that.
// - blank = 1
//   - digit_sel is forced to 0 combinationally before the output register.
//   - FSM, idx and counters keep running, so the scan phase is preserved.
//   - frame_done still pulses.
//   - bin_out still tracks idx.
// - load and frame boundary in the same cycle: the load takes effect; frame_done pulses normally.
// - digit_sel is never more than one-hot; in GUARD, or when blank = 1, it is all-zero.
// CONFIGURATION
// - SEG_LZB_EN defined: leading-zero blanking.
//   - Per frame, the digits above the most significant nonzero shadow nibble have digit_sel forced to 0 in DRIVE.
//   - Digit 0 is never blanked, so shadow == 0 shows a single "0".
//   - Blanking is computed from the shadow register, so it updates with load.
// - SEG_LZB_EN undefined: all NUM_DIGITS digits are always driven. No extra logic is generated.
// TESTING
// - Use bench params NUM_DIGITS=4, DWELL_CYCLES=4, GUARD_CYCLES=2.
// - T1 reset
//   - Stimulus: rst high 3 cycles, then low.
//   - Response: digit_sel = 0 for 3 cycles, then 0001 for exactly 4 cycles.
// - T2 scan order
//   - Stimulus: load digits_in = 16'h1A2F.
//   - Response: bin_out/digit_sel sequence F/0001, 2/0010, A/0100, 1/1000, repeating.
//   - Each DRIVE window is 4 cycles; each all-zero gap is 2 cycles.
//   - frame_done pulses once per 24 cycles.
// - T3 blank
//   - Stimulus: blank = 1 for 10 cycles mid-frame.
//   - Response: digit_sel = 0 throughout; after release, the scan resumes at the phase it would have reached without blanking.
// - T4 load during DRIVE
//   - Stimulus: load 16'h0005 at cycle 2 of digit 0's dwell.
//   - Response: bin_out switches to 5 on the next cycle; digit_sel unchanged.
// - T5 reset mid-operation
//   - Stimulus: assert rst during DRIVE of digit 2.
//   - Response: outputs return to 0 next edge; the scan restarts at digit 0 after the guard.
// - T6 SEG_LZB_EN
//   - T6a: load 16'h0030 -> digits 3 and 2 have digit_sel = 0 in DRIVE; digits 1 and 0 are driven.
//   - T6b: load 16'h0000 -> only digit 0 is driven.
//   - Without the macro: all four digits are driven.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// Bundle of the digit-scanner data/control signals.
// The master side (the producer of hex digits) drives digits_in/load/blank and
// observes the scanner outputs; the slave side is the scanner itself.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic                    blank;
  logic [3:0]              bin_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;

  modport master (
    output digits_in,
    output load,
    output blank,
    input  bin_out,
    input  digit_sel,
    input  frame_done
  );

  modport slave (
    input  digits_in,
    input  load,
    input  blank,
    output bin_out,
    output digit_sel,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes NUM_DIGITS hex nibbles onto one shared
// 7-segment decoder input, with one-hot digit enables and an all-off guard
// gap between digits to avoid ghosting.
//
// Build option: define SEG_LZB_EN for leading-zero blanking (digits above the
// most significant nonzero shadow nibble stay dark; digit 0 is always shown).
// Without the macro every digit is driven and no blanking logic exists.
//
// The interface instance must be built with the same NUM_DIGITS as this module.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_mux_if.slave  bus
);

  localparam int MAX_CYC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] shadow_reg;

  logic [3:0]              bin_out_reg, bin_out_next;
  logic [NUM_DIGITS-1:0]   digit_sel_reg, digit_sel_next;
  logic                    frame_done_reg, frame_done_next;

  // Per-digit views of the shadow register and of the scan position.
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   drive_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi]    = shadow_reg[4*gi +: 4];
      assign onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef SEG_LZB_EN
  // A digit is kept lit when it or any more significant nibble is nonzero;
  // digit 0 is unconditionally kept so an all-zero value still shows "0".
  logic [NUM_DIGITS-1:0] lzb_keep;

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      if (gi == 0) begin : g_lsd
        assign lzb_keep[gi] = 1'b1;
      end else begin : g_upper
        assign lzb_keep[gi] = |shadow_reg[4*NUM_DIGITS-1 : 4*gi];
      end
    end
  endgenerate

  assign drive_mask = onehot & lzb_keep;
`else
  assign drive_mask = onehot;
`endif

  // Shadow register: captures a full set of digits on the load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= '0;
    end else if (bus.load) begin
      shadow_reg <= bus.digits_in;
    end
  end

  // FSM state, dwell/guard counter and digit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_GUARD;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic: count out the guard gap, then the dwell, then advance.
  // Blank does not touch this path, so the scan phase is preserved.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    case (state_reg)
      S_GUARD: begin
        if (cnt_reg == GUARD_LAST) begin
          cnt_next   = '0;
          state_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_reg == DWELL_LAST) begin
          cnt_next   = '0;
          state_next = S_GUARD;
          idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = S_GUARD;
      end
    endcase
  end

  // Output decode: nibble of the current index, enable only while driving
  // and not blanked, frame pulse at the end of the last digit's dwell.
  always_comb begin
    bin_out_next    = nib[idx_reg];
    digit_sel_next  = '0;
    frame_done_next = 1'b0;
    if (state_reg == S_DRIVE) begin
      if (!bus.blank) begin
        digit_sel_next = drive_mask;
      end
      frame_done_next = (cnt_reg == DWELL_LAST) && (idx_reg == IDX_LAST);
    end
  end

  // Output register: glitch-free drive of the decoder and digit commons.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out_reg    <= '0;
      digit_sel_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      bin_out_reg    <= bin_out_next;
      digit_sel_reg  <= digit_sel_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bus.bin_out    = bin_out_reg;
  assign bus.digit_sel  = digit_sel_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (NUM_DIGITS=4, DWELL=4, GUARD=2).
// Stimulus pushes the expected output word for every clock; a negedge monitor
// pops and compares it against the DUT.
module tb_seg_scan_mux;

  localparam int ND    = 4;
  localparam int DWELL = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = DWELL + GUARD;   // 6 cycles per digit
  localparam int FRAME = ND * SLOT;       // 24 cycles per frame

  typedef struct {
    logic [3:0] sel;
    logic [3:0] bin;
    logic       fd;
    logic       care_bin;
    int         t;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   checks;
  int   errors;
  int   t;          // cycles since the last reset edge
  logic [15:0] sh_m; // expected shadow register contents

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DWELL),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after a non-reset edge, from the scan timing:
  // cycle t>=1 sits at position u=(t-1) mod 24; each digit slot is 2 dark
  // cycles then 4 driven cycles; the frame pulse lands on the final one.
  function automatic exp_t model(input logic bl);
    exp_t e;
    int   u, slot, off;
    logic keep;
    u    = (t - 1) % FRAME;
    slot = u / SLOT;
    off  = u % SLOT;
`ifdef SEG_LZB_EN
    keep = (slot == 0) || ((sh_m >> (4 * slot)) != 16'h0);
`else
    keep = 1'b1;
`endif
    e.t        = t;
    e.care_bin = (off >= GUARD);
    e.bin      = sh_m[4*slot +: 4];
    e.sel      = (off >= GUARD && !bl && keep) ? 4'(1 << slot) : 4'h0;
    e.fd       = (u == FRAME - 1);
    return e;
  endfunction

  // One clock of stimulus; the expectation for the following cycle is queued.
  task automatic tick(input logic rs, input logic ld, input logic [15:0] d, input logic bl);
    exp_t e;
    rst           = rs;
    bus.load      = ld;
    bus.digits_in = d;
    bus.blank     = bl;
    @(posedge clk);
    if (rs) begin
      t    = 0;
      sh_m = 16'h0;
      e    = '{sel: 4'h0, bin: 4'h0, fd: 1'b0, care_bin: 1'b1, t: 0};
    end else begin
      t++;
      e = model(bl);
      if (ld) sh_m = d;
    end
    q.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // Monitor: compare the DUT outputs against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (bus.digit_sel !== e.sel) begin
        errors++;
        $display("FAIL digit_sel t=%0d got %b want %b", e.t, bus.digit_sel, e.sel);
      end
      checks++;
      if (bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL frame_done t=%0d got %b want %b", e.t, bus.frame_done, e.fd);
      end
      if (e.care_bin) begin
        checks++;
        if (bus.bin_out !== e.bin) begin
          errors++;
          $display("FAIL bin_out t=%0d got %h want %h", e.t, bus.bin_out, e.bin);
        end
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    t             = 0;
    sh_m          = 16'h0;
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.blank     = 1'b0;
    bus.digits_in = 16'h0;

    // T1: reset for 3 cycles, then scan an all-zero shadow.
    repeat (3) tick(1'b1, 1'b0, 16'h0, 1'b0);
    run(30);

    // T2: scan order F,2,A,1 over two full frames.
    tick(1'b0, 1'b1, 16'h1A2F, 1'b0);
    run(48);

    // T3: blank mid-frame for 10 cycles; phase must be preserved.
    run(3);
    repeat (10) tick(1'b0, 1'b0, 16'h0, 1'b1);
    run(20);

    // T4: load 0005 during digit 0's dwell; bin_out switches next cycle.
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    tick(1'b0, 1'b1, 16'h1A2F, 1'b0);
    run(3);
    tick(1'b0, 1'b1, 16'h0005, 1'b0);
    run(11);

    // T5: reset while digit 2 is driven; scan restarts at digit 0.
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    run(30);

    // T6: leading-zero cases (all digits driven in the default build).
    tick(1'b0, 1'b1, 16'h0030, 1'b0);
    run(30);
    tick(1'b0, 1'b1, 16'h0000, 1'b0);
    run(30);

    // Load coinciding with the frame boundary.
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    run(23);
    tick(1'b0, 1'b1, 16'hBEEF, 1'b0);
    run(26);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
